color_ref_capture_ctrl: RTL and testbench

Sequences reference-colour extraction for the colour-detect path. It debounces the extract button, arms on a press, and waits for the next frame start. It then accumulates the 32x32 centre window over 2^FRAMES_LOG2 whole frames, divides by shift, and commits the result to the reference-colour register that feeds the binariser. It also owns clear and status, replacing the free-running accumulator/latch in the detect top.

---
 rtl/color_detect_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 52 +++++
 rtl/color_ref_capture_ctrl.sv | 164 ++++++++++++++++
 tb/tb_color_ref_capture_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_detect_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : color_detect_pkg                                           |
// | Brief   : Shared types and constants for the colour-detect path.     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package color_detect_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACCUM  = 2'd2,
        DIVIDE = 2'd3
    } state_t;

    localparam int          WIN_HALF  = 16;
    localparam int          WIN_LOG2  = 10;
    localparam int          SUM_W     = 22;
    localparam logic [23:0] REF_CLEAR = 24'hFFFFFF;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : btn_debounce                                               |
// | Brief   : 2-FF synchroniser, stable-level filter, rising press pulse.|
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic pclk,
    input  logic rst_n,
    input  logic btn_in,
    output logic press
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync0;
    logic               r_sync1;
    logic               r_stable;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;

    // The counter only runs while the synced level disagrees with the accepted one.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            r_sync0  <= 1'b0;
            r_sync1  <= 1'b0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync0 <= btn_in;
            r_sync1 <= r_sync0;
            r_press <= 1'b0;
            if (r_sync1 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_cnt    <= '0;
                r_stable <= r_sync1;
                r_press  <= r_sync1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/color_ref_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : color_ref_capture_ctrl                                     |
// | Brief   : Button-armed, frame-aligned centre-window colour capture.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module color_ref_capture_ctrl
    import color_detect_pkg::*;
#(
    parameter int IMG_WIDTH       = 320,
    parameter int IMG_HEIGHT      = 240,
    parameter int FRAMES_LOG2     = 0,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        btn_extract,
    input  logic        sw_clear,
    input  logic [11:0] h_cnt,
    input  logic [10:0] v_cnt,
    input  logic [23:0] rgb,
    output logic [23:0] ref_rgb,
    output logic        ref_valid,
    output logic        busy,
    output logic        capture_done
);

    localparam logic [11:0] c_H_LO       = 12'(IMG_WIDTH / 2 - WIN_HALF);
    localparam logic [11:0] c_H_HI       = 12'(IMG_WIDTH / 2 + WIN_HALF);
    localparam logic [10:0] c_V_LO       = 11'(IMG_HEIGHT / 2 - WIN_HALF);
    localparam logic [10:0] c_V_HI       = 11'(IMG_HEIGHT / 2 + WIN_HALF);
    localparam logic [10:0] c_V_SOF      = 11'd1;
    localparam logic [10:0] c_V_EOF      = 11'(IMG_HEIGHT - 2);
    localparam int          c_SHIFT      = WIN_LOG2 + FRAMES_LOG2;
    localparam logic [3:0]  c_LAST_FRAME = 4'((1 << FRAMES_LOG2) - 1);

    state_t             r_state;
    state_t             w_next;
    logic               w_press;
    logic               w_in_win;
    logic               w_sof;
    logic               w_eof;
    logic               w_start;
    logic               w_add;
    logic               w_frame_inc;
    logic               w_commit;
    logic [23:0]        w_div;
    logic [SUM_W-1:0]   r_sum_r;
    logic [SUM_W-1:0]   r_sum_g;
    logic [SUM_W-1:0]   r_sum_b;
    logic [3:0]         r_frame_cnt;
    logic [23:0]        r_ref_rgb;
    logic               r_ref_valid;
    logic               r_done;
    logic               w_unused;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .pclk   (pclk),
        .rst_n  (rst_n),
        .btn_in (btn_extract),
        .press  (w_press)
    );

    assign w_in_win = (h_cnt >= c_H_LO) && (h_cnt < c_H_HI) &&
                      (v_cnt >= c_V_LO) && (v_cnt < c_V_HI);
    assign w_sof    = (v_cnt == c_V_SOF) && (h_cnt == 12'd0);
    assign w_eof    = (v_cnt == c_V_EOF) && (h_cnt == 12'd0);

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Clear overrides every other event, including a pending commit.
    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_add       = 1'b0;
        w_frame_inc = 1'b0;
        w_commit    = 1'b0;
        if (sw_clear) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_press) begin
                        w_next = ARMED;
                    end
                end
                ARMED: begin
                    if (w_sof) begin
                        w_next  = ACCUM;
                        w_start = 1'b1;
                    end
                end
                ACCUM: begin
                    w_add = w_in_win;
                    if (w_eof) begin
                        if (r_frame_cnt == c_LAST_FRAME) begin
                            w_next = DIVIDE;
                        end else begin
                            w_frame_inc = 1'b1;
                        end
                    end
                end
                DIVIDE: begin
                    w_commit = 1'b1;
                    w_next   = IDLE;
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n || sw_clear || w_start) begin
            r_sum_r     <= '0;
            r_sum_g     <= '0;
            r_sum_b     <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (w_add) begin
                r_sum_r <= r_sum_r + SUM_W'(rgb[23:16]);
                r_sum_g <= r_sum_g + SUM_W'(rgb[15:8]);
                r_sum_b <= r_sum_b + SUM_W'(rgb[7:0]);
            end
            if (w_frame_inc) begin
                r_frame_cnt <= r_frame_cnt + 4'd1;
            end
        end
    end

    // Divide by pixel count times frame count is a plain bit select.
    assign w_div = {r_sum_r[c_SHIFT +: 8], r_sum_g[c_SHIFT +: 8], r_sum_b[c_SHIFT +: 8]};

    always_ff @(posedge pclk) begin
        if (!rst_n || sw_clear) begin
            r_ref_rgb   <= REF_CLEAR;
            r_ref_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                r_ref_rgb   <= w_div;
                r_ref_valid <= 1'b1;
            end
        end
    end

    assign ref_rgb      = r_ref_rgb;
    assign ref_valid    = r_ref_valid;
    assign capture_done = r_done;
    assign busy         = (r_state != IDLE);
    assign w_unused     = ^{r_sum_r, r_sum_g, r_sum_b};

endmodule
`default_nettype wire

// File: tb/tb_color_ref_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_color_ref_capture_ctrl                                  |
// | Brief   : Scoreboard bench, two DUTs averaging over 1 and 2 frames.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_color_ref_capture_ctrl;

    // Reduced frame geometry keeps the run short; window and markers still fit.
    localparam int IMG_W   = 48;
    localparam int IMG_H   = 40;
    localparam int H_TOTAL = 52;
    localparam int V_TOTAL = 42;
    localparam int H_LO    = IMG_W / 2 - 16;
    localparam int H_HI    = IMG_W / 2 + 16;
    localparam int V_LO    = IMG_H / 2 - 16;
    localparam int V_HI    = IMG_H / 2 + 16;
    localparam int V_EOF   = IMG_H - 2;

    typedef struct {
        logic [23:0] rgb;
        int          frame;
    } exp_t;

    logic        pclk;
    logic        rst_n;
    logic        btn_extract;
    logic        sw_clear;
    logic [11:0] h_cnt;
    logic [10:0] v_cnt;
    logic [23:0] rgb;
    logic [23:0] ref0, ref1;
    logic        valid0, valid1, busy0, busy1, done0, done1;

    int          h, v, fr;
    int          checks = 0;
    int          errors = 0;
    int          mode [32];
    logic [23:0] cval [32];
    logic [31:0] seed [32];
    exp_t        q0[$];
    exp_t        q1[$];

    color_ref_capture_ctrl #(
        .IMG_WIDTH(IMG_W), .IMG_HEIGHT(IMG_H), .FRAMES_LOG2(0), .DEBOUNCE_CYCLES(4)
    ) dut0 (
        .pclk(pclk), .rst_n(rst_n), .btn_extract(btn_extract), .sw_clear(sw_clear),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .rgb(rgb), .ref_rgb(ref0), .ref_valid(valid0),
        .busy(busy0), .capture_done(done0)
    );

    color_ref_capture_ctrl #(
        .IMG_WIDTH(IMG_W), .IMG_HEIGHT(IMG_H), .FRAMES_LOG2(1), .DEBOUNCE_CYCLES(4)
    ) dut1 (
        .pclk(pclk), .rst_n(rst_n), .btn_extract(btn_extract), .sw_clear(sw_clear),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .rgb(rgb), .ref_rgb(ref1), .ref_valid(valid1),
        .busy(busy1), .capture_done(done1)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic logic [23:0] pix(input int f, input int hh, input int vv);
        logic [31:0] x;
        int          fi;
        fi = (f > 31) ? 31 : f;
        case (mode[fi])
            1:       return cval[fi];
            2:       return (hh % 2 == 0) ? 24'h010101 : 24'h020202;
            default: begin
                x = seed[fi] ^ (32'(hh) * 32'h9E3779B1) ^ (32'(vv) * 32'h85EBCA6B);
                x = x ^ (x >> 15);
                x = x * 32'h2C1B3C6D;
                x = x ^ (x >> 12);
                return x[23:0];
            end
        endcase
    endfunction

    // Mean of the centre window over 2^lg frames starting at f0, truncated.
    function automatic logic [23:0] expect_ref(input int f0, input int lg);
        int          sr, sg, sb, sh;
        logic [23:0] p;
        sr = 0; sg = 0; sb = 0;
        for (int f = f0; f < f0 + (1 << lg); f++)
            for (int vv = V_LO; vv < V_HI; vv++)
                for (int hh = H_LO; hh < H_HI; hh++) begin
                    p  = pix(f, hh, vv);
                    sr += int'(p[23:16]);
                    sg += int'(p[15:8]);
                    sb += int'(p[7:0]);
                end
        sh = 10 + lg;
        return {8'(sr >> sh), 8'(sg >> sh), 8'(sb >> sh)};
    endfunction

    // Video timing and pixel source.
    initial begin
        for (int i = 0; i < 32; i++) begin
            mode[i] = 0;
            cval[i] = 24'h0;
            seed[i] = $urandom;
        end
        mode[2] = 1; cval[2] = 24'h123456;
        mode[3] = 1; cval[3] = 24'h123456;
        mode[5] = 1; cval[5] = 24'hFF0000;
        mode[6] = 1; cval[6] = 24'h000000;
        mode[8] = 2;
        mode[9] = 2;
        h = 0; v = 0; fr = 0;
        h_cnt = '0; v_cnt = '0; rgb = pix(0, 0, 0);
        forever begin
            @(negedge pclk);
            if (h == H_TOTAL - 1) begin
                h = 0;
                if (v == V_TOTAL - 1) begin
                    v = 0;
                    fr++;
                end else begin
                    v++;
                end
            end else begin
                h++;
            end
            h_cnt = 12'(h);
            v_cnt = 11'(v);
            rgb   = pix(fr, h, v);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge pclk);
        #1;
    endtask

    task automatic wait_pos(input int f, input int vv);
        for (int i = 0; i < 10000; i++) begin
            step();
            if (fr == f && v == vv && h == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_pos timeout: got frame %0d line %0d expected frame %0d line %0d", fr, v, f, vv);
    endtask

    task automatic capture(input int p, input bit push);
        exp_t e;
        wait_pos(p, 20);
        btn_extract = 1'b1;
        if (push) begin
            e.rgb = expect_ref(p + 1, 0); e.frame = p + 1; q0.push_back(e);
            e.rgb = expect_ref(p + 1, 1); e.frame = p + 2; q1.push_back(e);
        end
        repeat (20) step();
        chk("busy0_after_press", 32'(busy0), 32'd1);
        chk("busy1_after_press", 32'(busy1), 32'd1);
    endtask

    task automatic mon_cap(input int idx, input logic [23:0] r, input logic val);
        exp_t e;
        if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_capture dut%0d: got capture_done=1 expected 0 (ref %h)", idx, r);
            return;
        end
        if (idx == 0) e = q0.pop_front();
        else          e = q1.pop_front();
        chk($sformatf("ref_rgb dut%0d", idx), 32'(r), 32'(e.rgb));
        chk($sformatf("ref_valid dut%0d", idx), 32'(val), 32'd1);
        chk($sformatf("commit_pos dut%0d", idx), {fr[15:0], v[7:0], h[7:0]},
            {e.frame[15:0], 8'(V_EOF), 8'd1});
    endtask

    // Monitor: samples just after each rising edge, when h/v still name the sampled pixel.
    always @(posedge pclk) begin
        #2;
        if (done0) mon_cap(0, ref0, valid0);
        if (done1) mon_cap(1, ref1, valid1);
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; btn_extract = 1'b0; sw_clear = 1'b0;
        repeat (10) step();
        rst_n = 1'b1;
        step();
        chk("reset ref0", 32'(ref0), 32'hFFFFFF);
        chk("reset ref1", 32'(ref1), 32'hFFFFFF);
        chk("reset valid0", 32'(valid0), 32'd0);
        chk("reset valid1", 32'(valid1), 32'd0);
        chk("reset busy0", 32'(busy0), 32'd0);
        chk("reset busy1", 32'(busy1), 32'd0);

        // A 3-cycle bounce must not pass the filter.
        wait_pos(0, 10);
        btn_extract = 1'b1;
        repeat (3) step();
        btn_extract = 1'b0;
        repeat (30) step();
        chk("bounce busy0", 32'(busy0), 32'd0);
        chk("bounce busy1", 32'(busy1), 32'd0);

        capture(1, 1); btn_extract = 1'b0;
        capture(4, 1); btn_extract = 1'b0;
        capture(7, 1); btn_extract = 1'b0;

        // Clear mid-accumulation, together with a new press.
        capture(10, 0); btn_extract = 1'b0;
        wait_pos(11, 20);
        chk("pre_clear busy0", 32'(busy0), 32'd1);
        chk("pre_clear valid0", 32'(valid0), 32'd1);
        sw_clear = 1'b1;
        btn_extract = 1'b1;
        repeat (30) step();
        chk("clear busy0", 32'(busy0), 32'd0);
        chk("clear busy1", 32'(busy1), 32'd0);
        chk("clear valid0", 32'(valid0), 32'd0);
        chk("clear valid1", 32'(valid1), 32'd0);
        chk("clear ref0", 32'(ref0), 32'hFFFFFF);
        chk("clear ref1", 32'(ref1), 32'hFFFFFF);
        sw_clear = 1'b0;
        btn_extract = 1'b0;
        repeat (20) step();
        chk("post_clear busy0", 32'(busy0), 32'd0);
        chk("post_clear busy1", 32'(busy1), 32'd0);

        capture(12, 1); btn_extract = 1'b0;

        // Held button across several frames: one capture only.
        capture(15, 1);
        wait_pos(18, 5);
        btn_extract = 1'b0;

        // Second press while busy is dropped.
        capture(18, 1); btn_extract = 1'b0;
        wait_pos(19, 20);
        btn_extract = 1'b1;
        repeat (20) step();
        btn_extract = 1'b0;

        wait_pos(21, 10);
        chk("pending q0", 32'(q0.size()), 32'd0);
        chk("pending q1", 32'(q1.size()), 32'd0);
        chk("final valid0", 32'(valid0), 32'd1);
        chk("final valid1", 32'(valid1), 32'd1);
        chk("final busy0", 32'(busy0), 32'd0);
        chk("final busy1", 32'(busy1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
